pmem_arbiter: RTL and testbench

//  Shares the single physical-memory port between the instruction-cache miss path (imem side of

---
 rtl/pmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_pmem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - physical-memory port arbiter between icache and dcache miss paths
//
// Purpose: grants the single pmem port to one requester at a time, holds the
//   grant until pmem_resp, routes the response back, bounds data-side priority
//   with a starvation streak counter and flags a hung memory with a watchdog.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_read, i_addr                  icache line-fill request (level) and address
//   i_rdata, i_resp                 icache fill data and done pulse
//   d_read, d_write, d_addr,        dcache fill / write-back request (level),
//   d_wdata                         address and write-back data
//   d_rdata, d_resp                 dcache fill data and done pulse
//   pmem_read, pmem_write,          physical-memory strobes, address and
//   pmem_addr, pmem_wdata           write data
//   pmem_rdata, pmem_resp           physical-memory read data and done pulse
//   busy                            high in any SERVE state
//   err_timeout                     sticky watchdog error
module pmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              busy,
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0]  LIMIT     = 4'(STARVE_LIMIT);
  // The watchdog trips on the serve cycle whose increment would reach TIMEOUT,
  // so err_timeout rises after exactly TIMEOUT unanswered serve cycles.
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  streak;
  logic [15:0] wdog;
  logic        d_pend;
  logic        grant_i;
  logic        grant_d;
  logic        serving;
  logic        timeout_hit;

  assign d_pend      = d_read | d_write;
  // I wins when it is alone or once D has had STARVE_LIMIT grants in a row
  // while I was waiting.
  assign grant_i     = i_read & (~d_pend | (streak >= LIMIT));
  assign grant_d     = d_pend & ~grant_i;
  assign serving     = (state == SERVE_I) || (state == SERVE_D);
  assign timeout_hit = serving & ~pmem_resp & (wdog == WDOG_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_i) begin
          state_nxt = SERVE_I;
        end else if (grant_d) begin
          state_nxt = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        // Memory cannot abort, so only a response or the watchdog ends a grant.
        if (pmem_resp || timeout_hit) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Starvation streak, watchdog and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak      <= 4'd0;
      wdog        <= 16'd0;
      err_timeout <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_i) begin
        streak <= 4'd0;
        wdog   <= 16'd0;
      end else if (grant_d) begin
        if (!i_read) begin
          streak <= 4'd0;
        end else if (streak != 4'hF) begin
          streak <= streak + 4'd1;
        end
        wdog <= 16'd0;
      end
    end else if (serving && !pmem_resp) begin
      wdog <= wdog + 16'd1;
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end

  // Outputs: strobes follow the live request inputs while a grant is held
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    case (state)
      SERVE_I: begin
        pmem_read = 1'b1;
        pmem_addr = i_addr;
      end
      SERVE_D: begin
        pmem_write = d_write;
        pmem_read  = d_read & ~d_write;
        pmem_addr  = d_addr;
        pmem_wdata = d_wdata;
      end
      default: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    endcase
  end

  assign busy    = serving;
  assign i_resp  = pmem_resp & (state == SERVE_I);
  assign d_resp  = pmem_resp & (state == SERVE_D);
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - self-checking bench for pmem_arbiter against a transaction-level model
module tb_pmem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int LIMIT  = 4;
  localparam int TOUT   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;
  logic              busy;
  logic              err_timeout;

  pmem_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(LIMIT), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: who owns the port, whether a dead cycle is due,
  // how many serve cycles have elapsed, the D streak and the sticky error.
  int owner;        // 0 none, 1 icache, 2 dcache
  bit dead;
  int served;
  int streak;
  bit m_err;
  int grants[$];

  int  mem_mode;    // 0 random latency, 1 silent, 2 manual, 3 fixed latency
  int  lat;
  bit  rand_req;
  bit  i_done, d_done;
  int  cnt_i, cnt_d;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner  = 0;
    dead   = 1'b0;
    served = 0;
    streak = 0;
    m_err  = 1'b0;
  endtask

  // Advance the model by one clock using the inputs that were held during the cycle.
  task automatic model_update();
    bit ip, dp;
    if (!rst_n) begin
      model_reset();
    end else if (owner != 0) begin
      if (pmem_resp) begin
        owner = 0;
        dead  = 1'b1;
      end else if (served + 1 == TOUT) begin
        m_err = 1'b1;
        owner = 0;
        dead  = 1'b1;
      end else begin
        served++;
      end
    end else if (dead) begin
      dead = 1'b0;
    end else begin
      ip = i_read;
      dp = d_read | d_write;
      if (ip && (!dp || streak >= LIMIT)) begin
        owner = 1; streak = 0; served = 0; grants.push_back(1);
      end else if (dp) begin
        owner  = 2;
        streak = ip ? ((streak < 15) ? streak + 1 : 15) : 0;
        served = 0;
        grants.push_back(2);
      end
    end
  endtask

  task automatic drive();
    if (mem_mode != 2) begin
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (mem_mode == 1) begin
        pmem_resp = 1'b0;
      end else if (owner != 0) begin
        if (lat == 0) lat = (mem_mode == 3) ? 4 : $urandom_range(1, 5);
        pmem_resp = (served == lat - 1);
      end else begin
        lat = 0;
        pmem_resp = (mem_mode == 0) && ($urandom_range(0, 7) == 0);
      end
    end
    if (rand_req) begin
      if (i_done) begin
        i_read = 1'b0; i_done = 1'b0;
      end else if (!i_read && $urandom_range(0, 3) == 0) begin
        i_read = 1'b1; i_addr = 16'($urandom);
      end
      if (d_done) begin
        d_read = 1'b0; d_write = 1'b0; d_done = 1'b0;
      end else if (!d_read && !d_write && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: d_read = 1'b1;
          1: d_write = 1'b1;
          default: begin d_read = 1'b1; d_write = 1'b1; end
        endcase
        d_addr  = 16'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  endtask

  task automatic compare();
    logic e_rd, e_wr, e_ir, e_dr;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wdata;
    if (!rst_n) model_reset();
    e_rd    = (owner == 1) || (owner == 2 && d_read && !d_write);
    e_wr    = (owner == 2) && d_write;
    e_addr  = (owner == 1) ? i_addr : (owner == 2) ? d_addr : '0;
    e_wdata = (owner == 2) ? d_wdata : '0;
    e_ir    = (owner == 1) && pmem_resp;
    e_dr    = (owner == 2) && pmem_resp;
    check("busy", busy, owner != 0);
    check("pmem_read", pmem_read, e_rd);
    check("pmem_write", pmem_write, e_wr);
    check("pmem_addr", pmem_addr, e_addr);
    check("pmem_wdata", pmem_wdata, e_wdata);
    check("i_resp", i_resp, e_ir);
    check("d_resp", d_resp, e_dr);
    check("i_rdata", i_rdata, pmem_rdata);
    check("d_rdata", d_rdata, pmem_rdata);
    check("err_timeout", err_timeout, m_err);
    if (e_ir) i_done = 1'b1;
    if (e_dr) d_done = 1'b1;
    if (i_resp === 1'b1) cnt_i++;
    if (d_resp === 1'b1) cnt_d++;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    drive();
    @(negedge clk);
    compare();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    grants.delete();
    i_done = 1'b0; d_done = 1'b0;
    cnt_i = 0; cnt_d = 0;
  endtask

  task automatic wait_done(input string tag, input bit want_i);
    int n = 0;
    while (!(want_i ? i_done : d_done) && n < 40) begin
      step();
      n++;
    end
    check(tag, want_i ? i_done : d_done, 1'b1);
  endtask

  initial begin
    int n;
    int ci;
    model_reset();
    mem_mode = 3; lat = 0; rand_req = 1'b0;
    i_done = 1'b0; d_done = 1'b0; cnt_i = 0; cnt_d = 0;

    // Reset state
    apply_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_strobes", {pmem_read, pmem_write}, 2'b00);

    // Single icache fill
    i_read = 1'b1; i_addr = 16'h0040;
    step();
    check("single_i_read", pmem_read, 1'b1);
    check("single_i_addr", pmem_addr, 16'h0040);
    wait_done("single_i_done", 1'b1);
    i_read = 1'b0;
    step();
    check("single_i_release", busy, 1'b0);
    step();
    check("single_i_pulses", cnt_i, 1);
    check("single_i_no_d", cnt_d, 0);

    // Write-back
    d_write = 1'b1; d_addr = 16'h8000; d_wdata = {16{8'hA5}};
    step();
    check("wb_write", pmem_write, 1'b1);
    check("wb_read", pmem_read, 1'b0);
    check("wb_addr", pmem_addr, 16'h8000);
    check("wb_wdata", pmem_wdata, {16{8'hA5}});
    wait_done("wb_done", 1'b0);
    d_write = 1'b0;
    step(); step();

    // Both D strobes: write wins
    d_read = 1'b1; d_write = 1'b1; d_done = 1'b0;
    step();
    check("both_write", pmem_write, 1'b1);
    check("both_read", pmem_read, 1'b0);
    wait_done("both_done", 1'b0);
    d_read = 1'b0; d_write = 1'b0;
    step(); step();

    // Contention: both held, expect D,D,D,D,I repeating
    apply_reset();
    mem_mode = 0;
    i_read = 1'b1; d_read = 1'b1;
    n = 0;
    while (grants.size() < 10 && n < 400) begin
      step();
      n++;
    end
    check("contend_grants", grants.size() >= 10, 1'b1);
    for (int k = 0; k < 10 && k < grants.size(); k++) begin
      check($sformatf("contend_order%0d", k), grants[k], ((k % 5) == 4) ? 1 : 2);
    end
    i_read = 1'b0; d_read = 1'b0;

    // Randomized traffic
    apply_reset();
    rand_req = 1'b1;
    for (int k = 0; k < 3000; k++) step();
    rand_req = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    for (int k = 0; k < 12; k++) step();

    // Watchdog timeout
    apply_reset();
    mem_mode = 1;
    i_read = 1'b1;
    ci = cnt_i;
    for (int k = 0; k < TOUT; k++) step();
    check("to_not_yet", err_timeout, 1'b0);
    check("to_busy", busy, 1'b1);
    step();
    check("to_err", err_timeout, 1'b1);
    check("to_release", busy, 1'b0);
    i_read = 1'b0;
    step();
    step();
    check("to_idle", busy, 1'b0);
    check("to_sticky", err_timeout, 1'b1);
    check("to_no_resp", cnt_i, ci);

    // Asynchronous reset in the middle of a write-back
    apply_reset();
    mem_mode = 1;
    d_write = 1'b1; d_addr = 16'h1234;
    n = 0;
    while (owner != 2 && n < 10) begin
      step();
      n++;
    end
    step();
    check("arst_pre", pmem_write, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_write", pmem_write, 1'b0);
    check("arst_busy", busy, 1'b0);
    model_reset();
    step();
    mem_mode = 2;
    rst_n = 1'b1; d_write = 1'b0; pmem_resp = 1'b1;
    ci = cnt_d;
    step();
    check("arst_no_dresp", cnt_d, ci);
    pmem_resp = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
